// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial WIDTH-bit subtractor. One full-subtractor cell
//                and a registered borrow process the operands LSB first.
//                Computes {barrow,d} = a - b - barrow1 and raises a
//                one-cycle done pulse WIDTH cycles after start is accepted.
//                Define SERIAL_SUB_OVF_EN to add the registered signed
//                overflow output ovf.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             barrow1,
  output logic [WIDTH-1:0] d,
  output logic             barrow,
  output logic             busy,
  output logic             done
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0]       c_st_idle  = 2'd0;
  localparam logic [1:0]       c_st_run   = 2'd1;
  localparam logic [1:0]       c_st_done  = 2'd2;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_as;
  logic [WIDTH-1:0] r_bs;
  logic             r_br;
  logic [WIDTH-2:0] r_acc;     // difference bits assembled so far
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_d;
  logic             r_barrow;
  logic             r_busy;
  logic             r_done;

  logic             w_bit;
  logic             w_bout;
  logic [WIDTH-1:0] w_shift;
  logic             w_accept;

  // Full-subtractor cell on the current LSBs plus the difference shift value
  always_comb begin
    w_bit    = r_as[0] ^ r_bs[0] ^ r_br;
    w_bout   = (~r_as[0] & r_bs[0]) | (~(r_as[0] ^ r_bs[0]) & r_br);
    w_shift  = {w_bit, r_acc};
    w_accept = start & ((r_state == c_st_idle) | (r_state == c_st_done));
  end

  // Sequencer: accept, step one bit per edge, publish result on the last step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_st_idle;
      r_as     <= '0;
      r_bs     <= '0;
      r_br     <= 1'b0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_d      <= '0;
      r_barrow <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_as    <= a;
        r_bs    <= b;
        r_br    <= barrow1;
        r_cnt   <= '0;
        r_state <= c_st_run;
        r_busy  <= 1'b1;
      end else begin
        case (r_state)
          c_st_run: begin
            r_br  <= w_bout;
            r_as  <= {1'b0, r_as[WIDTH-1:1]};
            r_bs  <= {1'b0, r_bs[WIDTH-1:1]};
            r_acc <= w_shift[WIDTH-1:1];
            if (r_cnt == c_cnt_last) begin
              r_d      <= w_shift;
              r_barrow <= w_bout;
              r_state  <= c_st_done;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
            end else begin
              r_cnt <= r_cnt + c_cnt_one;
            end
          end
          c_st_done: r_state <= c_st_idle;
          default:   r_state <= c_st_idle;
        endcase
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // Overflow = borrow into MSB step XOR borrow out of MSB step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && (r_state == c_st_run) && (r_cnt == c_cnt_last)) begin
      r_ovf <= r_br ^ w_bout;
    end
  end

  assign ovf = r_ovf;
`endif

  assign d      = r_d;
  assign barrow = r_barrow;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor built around a single full-subtractor cell and a registered borrow.
- Accepts operands `a` and `b` plus an incoming borrow on a `start` pulse.
- Processes one bit per clock, LSB first.
- Returns the registered difference and final borrow with a one-cycle `done` pulse.
- Sits between the operand source and the single-bit subtractor cell, trading latency for area in wide subtractions.

## Interface
- `WIDTH`, default 8: operand and difference width in bits; legal range is 2 to 64.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request strobe; accepted only while `busy`=0.
- `a`  in  WIDTH: minuend; sampled on the accepting edge.
- `b`  in  WIDTH: subtrahend; sampled on the accepting edge.
- `barrow1`  in  1: incoming borrow; sampled on the accepting edge.
- `d`  out  WIDTH: difference register.
- `barrow`  out  1: final borrow-out register.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle completion pulse.
- `ovf`  out  1: signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- **States and transitions**
  - IDLE to RUN on `start` while `busy`=0.
  - RUN to DONE after WIDTH bit steps.
  - DONE to IDLE unconditionally, or DONE to RUN if `start` is high.
- **Accept edge:** loads the shift registers `as` and `bs` from `a` and `b`, loads the borrow register `br` from `barrow1`, and clears the bit counter.
- **RUN step (each edge)**
  - `bit = as[0]^bs[0]^br`.
  - `br <= (~as[0]&bs[0]) | (~(as[0]^bs[0])&br)`.
  - Shift `as` and `bs` right by one.
  - Shift the difference register right, inserting `bit` at the MSB.
  - Increment the counter.
- **Completion (WIDTH-th step)**
  - Copy the assembled difference to `d` and the final borrow to `barrow`.
  - Enter DONE with `done`=1.
- **Output hold:** `d` and `barrow` change only on completion or reset, and hold between operations.
- **Arithmetic result:** `{barrow,d} = a - b - barrow1` modulo 2^(WIDTH+1); `barrow`=1 iff `a < b + barrow1` as unsigned values.
- **Start while busy:** `start` during RUN is ignored; it is neither queued nor affects the operation in flight.
- **Operand inputs:** `a`, `b` and `barrow1` are don't-care outside the accept edge.
- **Reset:** async `rst` from any state, including mid-RUN, forces IDLE.
  - `d`=0, `barrow`=0, `busy`=0, `done`=0, `ovf`=0.
  - All internal registers, including the counter, are cleared.
  - The partial result is discarded and no `done` is produced.

## Timing
- **Latency:** `start` is accepted at edge E0; RUN edges are E1 through E(WIDTH).
  - `busy` is high from after E0 until after E(WIDTH).
  - `d`, `barrow`, `ovf` and `done` are valid after E(WIDTH).
  - `done` is high for exactly one cycle; latency is WIDTH cycles.
- **Back-to-back:** `start` high during the `done` cycle is accepted. The next operation starts with no idle gap, giving a throughput of one result per WIDTH+1 cycles.
- **Repeated start:** `start` held high continuously restarts at every DONE cycle.
- **Glitch-free outputs:** all outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - `ovf` port and logic are present.
  - On completion, `ovf` = (borrow into the MSB step) XOR (borrow out of the MSB step), i.e. two's-complement overflow of `a - b - barrow1`.
  - `ovf` is registered with `d` and held like `d`.
- `SERIAL_SUB_OVF_EN` undefined:
  - No `ovf` port and no extra registers.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- **Basic subtraction:** a=0x5A, b=0x23, barrow1=0, `start` at E0 → `done` after E8 with d=0x37, barrow=0; `busy` high for 8 cycles.
- **Underflow:** a=0x00, b=0x01, barrow1=0 → d=0xFF, barrow=1.
- **Borrow in:** a=0x10, b=0x10, barrow1=1 → d=0xFF, barrow=1. Then a=0xFF, b=0x00, barrow1=1 → d=0xFE, barrow=0.
- **Ignored start:** pulse `start` with a=0x01, b=0x00 at E3 of an operation on a=0x5A, b=0x23 → the single result is d=0x37; no extra `done` pulse appears.
- **Reset mid-operation:** assert `rst` asynchronously at E4 of a=0x00, b=0x01 → `busy`, `done`, `d` and `barrow` are 0 immediately. After release, a=0x05, b=0x03 gives d=0x02, barrow=0, `done` exactly 8 cycles after `start`.
- **Back-to-back and overflow:** `start` held high across the `done` cycle, with ops 0x80-0x01 then 0x7F-0xFF.
  - Results are d=0x7F, barrow=0, then d=0x80, barrow=1.
  - `done` pulses are 9 cycles apart.
  - With `SERIAL_SUB_OVF_EN`, `ovf`=1 for both; for 0x5A-0x23, `ovf`=0.
